// File: rtl/sha256_csa_accumulator_if.sv
`default_nettype none
// ============================================================================
// sha256_csa_accumulator_if : operand stream in, resolved sum out.
// Rev 1.0
// ============================================================================
interface sha256_csa_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface
`default_nettype wire

// File: rtl/sha256_csa_accumulator.sv
`default_nettype none
// ============================================================================
// sha256_csa_accumulator : carry-save multi-operand adder mod 2^WIDTH.
// Rev 1.0
// ============================================================================
module sha256_csa_accumulator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  sha256_csa_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] w_maj;
  logic             w_accept;

  assign w_accept = bus.in_valid && (state_q == ST_ACCUM);
  assign w_maj    = (s_q & c_q) | (bus.in_data & (s_q ^ c_q));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    count_d = count_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (w_accept) begin
          s_d   = s_q ^ c_q ^ bus.in_data;
          // Carry out of the MSB falls off: arithmetic is mod 2^WIDTH.
          c_d   = {w_maj[WIDTH-2:0], 1'b0};
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        sum_d   = s_q + c_q;
        count_d = cnt_q;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_OUTPUT);
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_csa_accumulator.sv
`default_nettype none
// ============================================================================
// tb_sha256_csa_accumulator : directed vectors for the CSA accumulator.
// Rev 1.0
// ============================================================================
module tb_sha256_csa_accumulator;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sha256_csa_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sha256_csa_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
    wait_out(tag);
    check({tag, "_sum"}, bus.out_sum, sum);
    check({tag, "_cnt"}, 32'(bus.out_count), cnt);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held_sum;
    logic [3:0]  held_cnt;
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", bus.out_sum, 32'h0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);

    // Single operand: RESOLVE cycle after accept, then OUTPUT.
    send(32'h12345678, 1'b1);
    check("single_lat_valid0", 32'(bus.out_valid), 32'd0);
    check("single_lat_ready0", 32'(bus.in_ready), 32'd0);
    tick();
    check("single_lat_valid1", 32'(bus.out_valid), 32'd1);
    expect_result("single", 32'h12345678, 32'd1);

    send(32'h6a09e667, 1'b0);
    send(32'hbb67ae85, 1'b1);
    expect_result("two", 32'h257194EC, 32'd2);

    for (int i = 0; i < 5; i++) send(32'hFFFFFFFF, (i == 4));
    expect_result("five_ones", 32'hFFFFFFFB, 32'd5);

    send(32'hFFFFFFFF, 1'b0);
    send(32'h00000001, 1'b1);
    expect_result("wrap", 32'h00000000, 32'd2);

    // Back-pressure: result held, inputs ignored while out_ready is low.
    send(32'h00000100, 1'b0);
    send(32'h00000200, 1'b1);
    wait_out("bp");
    held_sum = bus.out_sum;
    held_cnt = bus.out_count;
    check("bp_sum", held_sum, 32'h00000300);
    check("bp_cnt", 32'(held_cnt), 32'd2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = $urandom;
      bus.in_last = 1'($urandom_range(0, 1));
      tick();
      check("bp_hold_sum", bus.out_sum, 32'h00000300);
      check("bp_hold_cnt", 32'(bus.out_count), 32'd2);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_released", 32'(bus.in_ready), 32'd1);
    send(32'h1, 1'b0);
    send(32'h2, 1'b1);
    expect_result("after_bp", 32'h3, 32'd2);

    for (int i = 0; i < 20; i++) send(32'h1, (i == 19));
    expect_result("sat", 32'h14, 32'hF);

    // Reset mid-stream discards the partial sum.
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum", bus.out_sum, 32'h0);
    check("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    send(32'hA, 1'b0);
    send(32'h5, 1'b1);
    expect_result("post_rst", 32'hF, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
